gerente_contexto: RTL and testbench
===================================

# gerente_contexto

Context-switch responder for the multitasking processor. It consumes the context-switch instruction (opcode 6'b111111) that the preemption timer injects: first operand is the branch address, second is the next context. It stalls the core, saves the current context's register file to the HD context store, restores the next context's registers from the HD, then loads the new PC and publishes the new context number. It sits between the control unit, the register file and the HD module; its `contexto` output feeds the timer and the HD.

## Interface
Parameters:
- NUM_REGS, 32, registers saved/restored per context, indices 0..NUM_REGS-1.
- SO_CONTEXTO, 0, context number of the OS; it is the reset value of `contexto`.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- req  in  1  context-switch instruction in execute stage, one-cycle pulse.
- end_desvio  in  32  branch target (value of rs field register).
- prox_contexto  in  32  next context number (value of rt field register).
- flag_pausa  out  1  stall core while switching.
- contexto  out  32  current context number.
- novo_pc  out  32  PC to load.
- pc_load  out  1  one-cycle PC load strobe.
- rf_addr  out  5  register file address (read or write).
- rf_rdata  in  32  register file read data, combinational from rf_addr.
- rf_wdata  out  32  register file write data.
- rf_we  out  1  register file write enable.
- hd_contexto  out  32  HD context selector.
- hd_pos  out  5  HD position within context.
- hd_wdata  out  32  HD write data.
- hd_we  out  1  HD write enable.
- hd_rdata  in  32  HD read data, valid one cycle after hd_pos/hd_contexto presented.

## Operation
- States: IDLE, SAVE, RESTORE, LOAD.
- IDLE: on req=1 latch end_desvio and prox_contexto; if prox_contexto == contexto go to LOAD, else clear idx, go to SAVE.
- SAVE: rf_addr=idx, hd_contexto=contexto, hd_pos=idx, hd_wdata=rf_rdata, hd_we=1; idx++; after idx=NUM_REGS-1 clear idx, go to RESTORE.
- RESTORE: idx runs 0..NUM_REGS (NUM_REGS+1 cycles). Read issued with hd_contexto=latched prox, hd_pos=idx while idx<NUM_REGS. Write with rf_we=1, rf_addr=idx-1, rf_wdata=hd_rdata while idx≥1. After idx=NUM_REGS go to LOAD.
- LOAD: novo_pc=latched end_desvio, pc_load=1, contexto<=latched prox; next state IDLE.
- flag_pausa=1 in SAVE, RESTORE and LOAD; 0 in IDLE.
- req while not IDLE is ignored; no queueing.
- Register 29 (PC saved by addpc) travels with the other registers; no special handling.
- Only low 5 bits of idx drive rf_addr/hd_pos; idx counter is 6 bits wide, no wrap-around.
- Outside their active states, rf_we, hd_we and pc_load are 0. Data/address outputs are 0 in IDLE.

## Timing
- Reset values: flag_pausa=0, pc_load=0, rf_we=0, hd_we=0, contexto=SO_CONTEXTO, novo_pc=0, all address/data outputs 0, state IDLE.
- req sampled at cycle 0. SAVE occupies cycles 1..NUM_REGS and RESTORE occupies cycles NUM_REGS+1..2·NUM_REGS+1. LOAD occurs at cycle 2·NUM_REGS+2, which is 66 for the default.
- New contexto is visible at cycle 2·NUM_REGS+3. flag_pausa falls in the same cycle.
- Same-context request: LOAD at cycle 1, contexto unchanged, flag_pausa high for exactly 1 cycle.
- rst_n=0 mid-operation: next edge returns to IDLE with reset values. HD writes already done are not undone, and contexto reverts to SO_CONTEXTO.
- req asserted in the same cycle as rst_n=0: reset wins, req is dropped.

## Structure
- Shared package/include: state encodings, opcode constant 6'b111111, SO_CONTEXTO, register indices 28/29/30 used by the timer sequence.
- Single module. Optional sub-module `contador_indice` (6-bit clearable up-counter with terminal flag) shared with the timer.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> contexto=0, flag_pausa=0, all strobes 0.
- Switch 1->2: contexto=1, rf preloaded r[i]=i+100, HD ctx2 preloaded i+200, req with end_desvio=337, prox=2. Required response: 32 HD writes ctx1 pos i = i+100 in cycles 1..32, then 32 rf writes r[i]=i+200 in cycles 34..65, then pc_load=1 with novo_pc=337 at cycle 66, contexto=2 at cycle 67.
- Same context: contexto=2, req with prox=2, end_desvio=55 -> no HD or rf writes, pc_load at cycle 1, flag_pausa high exactly 1 cycle.
- req pulses while busy: extra req at cycles 10 and 40 -> ignored, trace identical to the 1->2 switch.
- Reset mid-switch: rst_n=0 at cycle 20 -> IDLE next edge, contexto=0, no pc_load.
- Round trip: switch 1->2, then 2->1 -> original r[i]=i+100 restored, contexto=1.

Source files
------------

// File: rtl/gerente_contexto_pkg.sv
// gerente_contexto_pkg: shared constants for the context-switch responder and the preemption timer
// Contents: FSM state encodings, context-switch opcode, OS context number,
//           register indices used by the timer's injected sequence.
package gerente_contexto_pkg;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SAVE    = 2'd1;
   localparam logic [1:0] S_RESTORE = 2'd2;
   localparam logic [1:0] S_LOAD    = 2'd3;
   localparam logic [5:0] OP_TROCA_CONTEXTO = 6'b111111;
   localparam logic [31:0] SO_CONTEXTO_PADRAO = 32'd0;
   localparam logic [4:0] REG_28 = 5'd28;
   localparam logic [4:0] REG_29 = 5'd29;
   localparam logic [4:0] REG_30 = 5'd30;
endpackage

// File: rtl/contador_indice.sv
// contador_indice: 6-bit clearable up-counter with terminal flag
// Ports: clk, rst_n (sync, active-low), clr (priority over inc), inc,
//        limite (terminal value), valor (count), terminal (valor == limite).
module contador_indice (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   input  logic [5:0] limite,
   output logic [5:0] valor,
   output logic       terminal
);
   logic [5:0] valor_q, valor_d;
   always_comb valor_d = clr ? 6'd0 : inc ? valor_q + 6'd1 : valor_q;
   always_ff @(posedge clk)
      if (!rst_n) valor_q <= 6'd0;
      else        valor_q <= valor_d;
   assign valor    = valor_q;
   assign terminal = valor_q == limite;
endmodule

// File: rtl/gerente_contexto.sv
// gerente_contexto: context-switch responder (save RF to HD, restore RF from HD, load PC)
// Ports: clk, rst_n (sync, active-low); req/end_desvio/prox_contexto from the
//        control unit; flag_pausa stalls the core; contexto is the current
//        context; novo_pc/pc_load load the PC; rf_* drive the register file;
//        hd_* drive the HD context store (hd_rdata has one cycle of latency).
module gerente_contexto
   import gerente_contexto_pkg::*;
#(
   parameter int          NUM_REGS    = 32,
   parameter logic [31:0] SO_CONTEXTO = SO_CONTEXTO_PADRAO
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [31:0] end_desvio,
   input  logic [31:0] prox_contexto,
   output logic        flag_pausa,
   output logic [31:0] contexto,
   output logic [31:0] novo_pc,
   output logic        pc_load,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_rdata,
   output logic [31:0] rf_wdata,
   output logic        rf_we,
   output logic [31:0] hd_contexto,
   output logic [4:0]  hd_pos,
   output logic [31:0] hd_wdata,
   output logic        hd_we,
   input  logic [31:0] hd_rdata
);
   logic [1:0]  estado_q, estado_d;
   logic [31:0] desvio_q, desvio_d, prox_q, prox_d, contexto_q, contexto_d;
   logic [5:0]  idx;
   logic        term, clr, inc;
   logic        em_save, em_rest, em_load, le, rd;
   contador_indice u_idx (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .inc      (inc),
      .limite   (estado_q == S_SAVE ? 6'(NUM_REGS - 1) : 6'(NUM_REGS)),
      .valor    (idx),
      .terminal (term)
   );
   always_comb begin
      estado_d   = estado_q;
      desvio_d   = desvio_q;
      prox_d     = prox_q;
      contexto_d = contexto_q;
      clr        = 1'b0;
      inc        = 1'b0;
      case (estado_q)
         S_IDLE: begin
            clr = 1'b1;
            if (req) begin
               desvio_d = end_desvio;
               prox_d   = prox_contexto;
               estado_d = prox_contexto == contexto_q ? S_LOAD : S_SAVE;
            end
         end
         S_SAVE: begin
            inc = 1'b1;
            clr = term;
            estado_d = term ? S_RESTORE : S_SAVE;
         end
         S_RESTORE: begin
            inc = 1'b1;
            clr = term;
            estado_d = term ? S_LOAD : S_RESTORE;
         end
         default: begin
            contexto_d = prox_q;
            estado_d   = S_IDLE;
         end
      endcase
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         estado_q   <= S_IDLE;
         desvio_q   <= 32'd0;
         prox_q     <= 32'd0;
         contexto_q <= SO_CONTEXTO;
      end else begin
         estado_q   <= estado_d;
         desvio_q   <= desvio_d;
         prox_q     <= prox_d;
         contexto_q <= contexto_d;
      end
   assign em_save = estado_q == S_SAVE;
   assign em_rest = estado_q == S_RESTORE;
   assign em_load = estado_q == S_LOAD;
   // RESTORE is a one-deep pipeline: read HD at idx, write the RF with the
   // data that arrives for idx-1.
   assign rd = em_rest && idx < 6'(NUM_REGS);
   assign le = em_rest && idx != 6'd0;
   assign rf_addr     = em_save ? idx[4:0] : le ? idx[4:0] - 5'd1 : 5'd0;
   assign rf_wdata    = le ? hd_rdata : 32'd0;
   assign rf_we       = le;
   assign hd_contexto = em_save ? contexto_q : rd ? prox_q : 32'd0;
   assign hd_pos      = em_save || rd ? idx[4:0] : 5'd0;
   assign hd_wdata    = em_save ? rf_rdata : 32'd0;
   assign hd_we       = em_save;
   assign novo_pc     = em_load ? desvio_q : 32'd0;
   assign pc_load     = em_load;
   assign flag_pausa  = estado_q != S_IDLE;
   assign contexto    = contexto_q;
endmodule

// File: tb/tb_gerente_contexto.sv
// tb_gerente_contexto: directed bench with a cycle-position model of the switch sequence
module tb_gerente_contexto;
   localparam int N = 32;
   logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0;
   logic [31:0] end_desvio = 32'd0, prox_contexto = 32'd0;
   logic        flag_pausa, pc_load, rf_we, hd_we;
   logic [31:0] contexto, novo_pc, rf_rdata, rf_wdata, hd_contexto, hd_wdata, hd_rdata;
   logic [4:0]  rf_addr, hd_pos;
   logic [31:0] rf_mem [N];
   logic [31:0] hd_mem [4][N];
   int total = 0, bad = 0, gc = 0, g0 = 0, pc_cyc = -1, n_hd = 0, n_rf = 0, n_fl = 0;
   int k = 0, j;
   logic armed = 1'b0;
   logic [31:0] m_ctx = 32'd0, m_prox = 32'd0, m_end = 32'd0;
   logic sv, rs, ld;

   gerente_contexto dut (
      .clk(clk), .rst_n(rst_n), .req(req), .end_desvio(end_desvio),
      .prox_contexto(prox_contexto), .flag_pausa(flag_pausa), .contexto(contexto),
      .novo_pc(novo_pc), .pc_load(pc_load), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
      .rf_wdata(rf_wdata), .rf_we(rf_we), .hd_contexto(hd_contexto), .hd_pos(hd_pos),
      .hd_wdata(hd_wdata), .hd_we(hd_we), .hd_rdata(hd_rdata)
   );

   always #5 clk = ~clk;

   assign rf_rdata = rf_mem[rf_addr];
   always @(posedge clk) begin
      hd_rdata <= hd_mem[hd_contexto[1:0]][hd_pos];
      if (hd_we) hd_mem[hd_contexto[1:0]][hd_pos] <= hd_wdata;
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
   end

   // k = position inside the current switch (0 = idle, 1..N save,
   // N+1..2N+1 restore, 2N+2 load)
   always @(posedge clk) begin
      gc++;
      if (!rst_n) begin
         k = 0;
         m_ctx = 32'd0;
      end else if (k == 0) begin
         if (req) begin
            m_prox = prox_contexto;
            m_end  = end_desvio;
            k = prox_contexto == m_ctx ? 2 * N + 2 : 1;
         end
      end else if (k == 2 * N + 2) begin
         m_ctx = m_prox;
         k = 0;
      end else k++;
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) if (armed) begin
      sv = k >= 1 && k <= N;
      rs = k >= N + 1 && k <= 2 * N + 1;
      ld = k == 2 * N + 2;
      j  = k - N - 1;
      chk("flag_pausa", {31'd0, flag_pausa}, {31'd0, k != 0});
      chk("contexto", contexto, m_ctx);
      chk("hd_we", {31'd0, hd_we}, {31'd0, sv});
      chk("hd_contexto", hd_contexto, sv ? m_ctx : (rs && j < N) ? m_prox : 32'd0);
      chk("hd_pos", {27'd0, hd_pos}, sv ? 32'(k - 1) : (rs && j < N) ? 32'(j) : 32'd0);
      chk("hd_wdata", hd_wdata, sv ? rf_mem[k - 1] : 32'd0);
      chk("rf_we", {31'd0, rf_we}, {31'd0, rs && j >= 1});
      chk("rf_addr", {27'd0, rf_addr}, sv ? 32'(k - 1) : (rs && j >= 1) ? 32'(j - 1) : 32'd0);
      chk("rf_wdata", rf_wdata, (rs && j >= 1) ? hd_mem[m_prox[1:0]][j - 1] : 32'd0);
      chk("pc_load", {31'd0, pc_load}, {31'd0, ld});
      chk("novo_pc", novo_pc, ld ? m_end : 32'd0);
      if (hd_we) n_hd++;
      if (rf_we) n_rf++;
      if (flag_pausa) n_fl++;
      if (pc_load) pc_cyc = gc - g0;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic switch_to(input logic [31:0] e, input logic [31:0] p, input int x1, input int x2, input int ra);
      n_hd = 0; n_rf = 0; n_fl = 0; pc_cyc = -1; g0 = gc;
      end_desvio = e; prox_contexto = p; req = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         tick;
         req   = c == x1 || c == x2;
         rst_n = c != ra;
      end
      req = 1'b0; rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rf_mem[i] <= 32'd0;
         for (int c = 0; c < 4; c++) hd_mem[c][i] <= 32'd0;
      end
      tick;
      armed = 1'b1;
      tick; tick;
      chk("reset contexto", contexto, 32'd0);
      chk("reset flag_pausa", {31'd0, flag_pausa}, 32'd0);
      chk("reset strobes", {29'd0, pc_load, rf_we, hd_we}, 32'd0);
      rst_n = 1'b1;
      tick;
      switch_to(32'd10, 32'd1, -1, -1, -1);
      chk("ctx after 0->1", contexto, 32'd1);
      for (int i = 0; i < N; i++) begin
         rf_mem[i] <= 32'(i + 100);
         hd_mem[2][i] <= 32'(i + 200);
      end
      tick;
      switch_to(32'd337, 32'd2, -1, -1, -1);
      chk("1->2 load cycle", pc_cyc, 66);
      chk("1->2 hd writes", n_hd, 32);
      chk("1->2 rf writes", n_rf, 32);
      chk("1->2 contexto", contexto, 32'd2);
      for (int i = 0; i < N; i++) begin
         chk("1->2 rf restored", rf_mem[i], 32'(i + 200));
         chk("1->2 hd saved", hd_mem[1][i], 32'(i + 100));
      end
      switch_to(32'd55, 32'd2, -1, -1, -1);
      chk("same load cycle", pc_cyc, 1);
      chk("same hd writes", n_hd, 0);
      chk("same rf writes", n_rf, 0);
      chk("same pause cycles", n_fl, 1);
      chk("same contexto", contexto, 32'd2);
      switch_to(32'd400, 32'd1, -1, -1, -1);
      chk("2->1 contexto", contexto, 32'd1);
      for (int i = 0; i < N; i++) chk("2->1 rf restored", rf_mem[i], 32'(i + 100));
      switch_to(32'd337, 32'd2, 10, 40, -1);
      chk("busy load cycle", pc_cyc, 66);
      chk("busy hd writes", n_hd, 32);
      chk("busy rf writes", n_rf, 32);
      chk("busy contexto", contexto, 32'd2);
      chk("busy r29", rf_mem[29], 32'd229);
      switch_to(32'd77, 32'd3, -1, -1, 20);
      chk("midrst pc_load", pc_cyc, -1);
      chk("midrst hd writes", n_hd, 20);
      chk("midrst rf writes", n_rf, 0);
      chk("midrst contexto", contexto, 32'd0);
      rst_n = 1'b0; req = 1'b1; prox_contexto = 32'd1;
      tick;
      req = 1'b0; rst_n = 1'b1;
      tick; tick;
      chk("rst+req flag_pausa", {31'd0, flag_pausa}, 32'd0);
      chk("rst+req contexto", contexto, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
